// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: prefix stall bus, multi-cycle EX countdown, exception flush/redirect.
// Optional STALL_PERF_EN adds a saturating stall_cycles counter port.
module pipe_hazard_ctrl #(
  parameter int NSTAGE   = 6,
  parameter int NREQ     = 4,
  parameter int MC_STAGE = 3,
  parameter int CW       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              mc_start,
  input  logic [CW-1:0]     mc_cycles,
  input  logic              excp_req,
  input  logic [31:0]       excp_pc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [1:0]        dbg_state
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   new_pc_q, new_pc_d;
  logic          mc_stall;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state: an exception overrides whatever the countdown would do.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (mc_start && (mc_cycles >= CW'(2))) begin
          state_d = MC_BUSY;
          cnt_d   = mc_cycles - CW'(1);
        end
      end
      MC_BUSY: begin
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (excp_req) begin
      state_d  = FLUSH;
      new_pc_d = excp_pc;
      cnt_d    = '0;
    end
  end

  // Outputs: request masks are prefix masks, so OR-ing them lets the deepest stage dominate.
  always_comb begin
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    stall    = '0;
    case (state_q)
      IDLE: begin
        if (mc_start) begin
          if (mc_cycles >= CW'(2)) mc_stall = 1'b1;
          else                     mc_done  = 1'b1;
        end
      end
      MC_BUSY: begin
        if (cnt_q > CW'(1)) mc_stall = 1'b1;
        else                mc_done  = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (stall_req[i] && (k <= i + 2)) stall[k] = 1'b1;
      end
    end
    for (int k = 0; k < NSTAGE; k++) begin
      if (mc_stall && (k <= MC_STAGE)) stall[k] = 1'b1;
    end
    if (state_q == FLUSH || rst) begin
      stall   = '0;
      mc_done = 1'b0;
    end
  end

  assign flush     = (state_q == FLUSH);
  assign new_pc    = new_pc_q;
  assign mc_busy   = (state_q == MC_BUSY) && !rst;
  assign dbg_state = state_q;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: stall masks, multi-cycle engine, flush/redirect, reset.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  stall_req;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
  logic [1:0]  dbg_state;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .mc_start(mc_start), .mc_cycles(mc_cycles),
    .excp_req(excp_req), .excp_pc(excp_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .mc_busy(mc_busy), .mc_done(mc_done), .dbg_state(dbg_state)
`ifdef STALL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall_req = 4'b0000;
    mc_start  = 1'b0;
    mc_cycles = 6'd0;
    excp_req  = 1'b0;
    excp_pc   = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    stall_req = 4'b1111;
    mc_start  = 1'b1;
    mc_cycles = 6'd1;
    step();
    sample();
    n_cmp++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL reset_stall got=%b exp=%b", stall, 6'b000000); end
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", mc_busy); end
    n_cmp++; if (mc_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", mc_done); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
    n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    step();
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_stall_mask();
    logic [3:0] req_v [5] = '{4'b0001, 4'b0011, 4'b1000, 4'b0100, 4'b0000};
    logic [5:0] exp_v [5] = '{6'b000111, 6'b001111, 6'b111111, 6'b011111, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      stall_req = req_v[i];
      sample();
      n_cmp++;
      if (stall !== exp_v[i]) begin
        n_bad++; $display("FAIL stall_mask req=%b got=%b exp=%b", req_v[i], stall, exp_v[i]);
      end
      step();
    end
  endtask

  task automatic test_multicycle();
    logic [5:0] exp_stall [5] = '{6'b001111, 6'b001111, 6'b001111, 6'b000000, 6'b000000};
    logic       exp_busy  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_done  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    idle_inputs();
    mc_start  = 1'b1;
    mc_cycles = 6'd4;
    for (int t = 0; t < 5; t++) begin
      sample();
      n_cmp++; if (stall !== exp_stall[t]) begin n_bad++; $display("FAIL mc4_stall t=%0d got=%b exp=%b", t, stall, exp_stall[t]); end
      n_cmp++; if (mc_busy !== exp_busy[t]) begin n_bad++; $display("FAIL mc4_busy t=%0d got=%b exp=%b", t, mc_busy, exp_busy[t]); end
      n_cmp++; if (mc_done !== exp_done[t]) begin n_bad++; $display("FAIL mc4_done t=%0d got=%b exp=%b", t, mc_done, exp_done[t]); end
      step();
      mc_start = 1'b0;
    end
    // EX held by a requester too: MEM request dominates the engine's prefix.
    mc_start  = 1'b1;
    mc_cycles = 6'd2;
    stall_req = 4'b0100;
    sample();
    n_cmp++; if (stall !== 6'b011111) begin n_bad++; $display("FAIL mc2_or got=%b exp=%b", stall, 6'b011111); end
    step();
    mc_start  = 1'b0;
    stall_req = 4'b0000;
    sample();
    n_cmp++; if (mc_done !== 1'b1) begin n_bad++; $display("FAIL mc2_done got=%b exp=1", mc_done); end
    n_cmp++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL mc2_stall got=%b exp=0", stall); end
    step();
  endtask

  task automatic test_single_cycle();
    for (int n = 0; n < 2; n++) begin
      idle_inputs();
      mc_start  = 1'b1;
      mc_cycles = 6'(n);
      sample();
      n_cmp++; if (mc_done !== 1'b1) begin n_bad++; $display("FAIL mc_short_done n=%0d got=%b exp=1", n, mc_done); end
      n_cmp++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL mc_short_stall n=%0d got=%b exp=0", n, stall); end
      step();
      mc_start = 1'b0;
      sample();
      n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL mc_short_busy n=%0d got=%b exp=0", n, mc_busy); end
      n_cmp++; if (mc_done !== 1'b0) begin n_bad++; $display("FAIL mc_short_done2 n=%0d got=%b exp=0", n, mc_done); end
      step();
    end
  endtask

  task automatic test_exception();
    idle_inputs();
    mc_start  = 1'b1;
    mc_cycles = 6'd4;
    step();
    mc_start  = 1'b0;
    excp_req  = 1'b1;
    excp_pc   = 32'hBFC0_0380;
    sample();
    n_cmp++; if (stall !== 6'b001111) begin n_bad++; $display("FAIL excp_cycle_stall got=%b exp=%b", stall, 6'b001111); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL excp_cycle_flush got=%b exp=0", flush); end
    step();
    excp_req  = 1'b0;
    excp_pc   = 32'h0;
    stall_req = 4'b1000;
    mc_start  = 1'b1;
    mc_cycles = 6'd3;
    sample();
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL excp_flush got=%b exp=1", flush); end
    n_cmp++; if (new_pc !== 32'hBFC0_0380) begin n_bad++; $display("FAIL excp_new_pc got=%h exp=bfc00380", new_pc); end
    n_cmp++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL excp_stall got=%b exp=0", stall); end
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL excp_busy got=%b exp=0", mc_busy); end
    n_cmp++; if (mc_done !== 1'b0) begin n_bad++; $display("FAIL excp_done got=%b exp=0", mc_done); end
    step();
    mc_start = 1'b0;
    sample();
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL excp_after_flush got=%b exp=0", flush); end
    n_cmp++; if (new_pc !== 32'hBFC0_0380) begin n_bad++; $display("FAIL excp_pc_hold got=%h exp=bfc00380", new_pc); end
    n_cmp++; if (stall !== 6'b111111) begin n_bad++; $display("FAIL excp_after_stall got=%b exp=%b", stall, 6'b111111); end
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL excp_mc_ignored got=%b exp=0", mc_busy); end
    stall_req = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      step();
      sample();
      n_cmp++; if (mc_done !== 1'b0) begin n_bad++; $display("FAIL excp_no_done t=%0d got=%b exp=0", t, mc_done); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    excp_req = 1'b1;
    excp_pc  = 32'h8000_0100;
    step();
    excp_pc  = 32'h8000_0200;
    sample();
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL b2b_flush1 got=%b exp=1", flush); end
    n_cmp++; if (new_pc !== 32'h8000_0100) begin n_bad++; $display("FAIL b2b_pc1 got=%h exp=80000100", new_pc); end
    step();
    excp_req = 1'b0;
    sample();
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL b2b_flush2 got=%b exp=1", flush); end
    n_cmp++; if (new_pc !== 32'h8000_0200) begin n_bad++; $display("FAIL b2b_pc2 got=%h exp=80000200", new_pc); end
    step();
    sample();
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL b2b_flush3 got=%b exp=0", flush); end
    step();
  endtask

  task automatic test_rst_during_busy();
    idle_inputs();
    mc_start  = 1'b1;
    mc_cycles = 6'd5;
    step();
    mc_start  = 1'b0;
    stall_req = 4'b0010;
    sample();
    n_cmp++; if (mc_busy !== 1'b1) begin n_bad++; $display("FAIL rstb_busy_before got=%b exp=1", mc_busy); end
    step();
    rst = 1'b1;
    sample();
    n_cmp++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL rstb_stall got=%b exp=0", stall); end
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL rstb_busy got=%b exp=0", mc_busy); end
    n_cmp++; if (mc_done !== 1'b0) begin n_bad++; $display("FAIL rstb_done got=%b exp=0", mc_done); end
    step();
    sample();
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rstb_flush got=%b exp=0", flush); end
    n_cmp++; if (mc_busy !== 1'b0) begin n_bad++; $display("FAIL rstb_busy2 got=%b exp=0", mc_busy); end
    rst = 1'b0;
    stall_req = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      step();
      sample();
      n_cmp++; if (mc_done !== 1'b0 || mc_busy !== 1'b0 || stall !== 6'b0) begin
        n_bad++; $display("FAIL rstb_after t=%0d done=%b busy=%b stall=%b exp 0/0/0", t, mc_done, mc_busy, stall);
      end
    end
    step();
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL perf_clear got=%0d exp=0", stall_cycles); end
    stall_req = 4'b0001;
    for (int t = 0; t < 5; t++) step();
    stall_req = 4'b0000;
    sample();
    n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL perf_count got=%0d exp=5", stall_cycles); end
    for (int t = 0; t < 3; t++) step();
    sample();
    n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL perf_hold got=%0d exp=5", stall_cycles); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_stall_mask();
    test_multicycle();
    test_single_cycle();
    test_exception();
    test_back_to_back();
    test_rst_during_busy();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
